// File: rtl/exec_sequencer.sv
// Run-control sequencer for the single-cycle-issue core: fetch/execute phasing,
// halt, free-run, single-step, one PC breakpoint and a retired-instruction counter.
//
// state | meaning
// HALT  | core idle, waiting for run or a step edge
// FETCH | program-memory load enable asserted
// EXEC  | register-file write enable asserted, instruction retires
module exec_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  bp_en,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  fetch_en,
  output logic                  exec_en,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   step_q;
  logic                   one_shot_q, one_shot_d;
  logic                   bp_hit_q, bp_hit_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   fetch_q, exec_q, halted_q;
  logic                   step_rise;
  logic                   bp_match;

  assign step_rise = step & ~step_q;
  assign bp_match  = bp_en && (pc_addr == bp_addr);

  always_comb begin
    state_d    = state_q;
    one_shot_d = one_shot_q;
    bp_hit_d   = bp_hit_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_HALT: begin
        // run takes priority over a coincident step edge
        if (run) begin
          state_d    = S_FETCH;
          one_shot_d = 1'b0;
          bp_hit_d   = 1'b0;
        end else if (step_rise) begin
          state_d    = S_FETCH;
          one_shot_d = 1'b1;
          bp_hit_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (!(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
        if (one_shot_q || !run) begin
          state_d = S_HALT;
        end else if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // Phase outputs are flopped alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HALT;
      step_q     <= 1'b0;
      one_shot_q <= 1'b0;
      bp_hit_q   <= 1'b0;
      cnt_q      <= '0;
      fetch_q    <= 1'b0;
      exec_q     <= 1'b0;
      halted_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      step_q     <= step;
      one_shot_q <= one_shot_d;
      bp_hit_q   <= bp_hit_d;
      cnt_q      <= cnt_d;
      fetch_q    <= (state_d == S_FETCH);
      exec_q     <= (state_d == S_EXEC);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign fetch_en    = fetch_q;
  assign exec_en     = exec_q;
  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Table-driven scoreboard bench for exec_sequencer; a 4-bit-counter copy shares
// the stimulus to cover counter saturation.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        bp_en = 1'b0;
  logic [4:0]  bp_addr = 5'd0;
  logic [4:0]  pc_addr = 5'd0;
  logic        fetch_en, exec_en, halted, bp_hit;
  logic [15:0] instr_count;
  logic        fetch_en4, exec_en4, halted4, bp_hit4;
  logic [3:0]  instr_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_addr(pc_addr), .fetch_en(fetch_en), .exec_en(exec_en),
    .halted(halted), .bp_hit(bp_hit), .instr_count(instr_count)
  );

  exec_sequencer #(.ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_addr(pc_addr), .fetch_en(fetch_en4), .exec_en(exec_en4),
    .halted(halted4), .bp_hit(bp_hit4), .instr_count(instr_count4)
  );

  typedef struct {
    logic        rst, run, stp, bpe;
    logic [4:0]  bpa, pca;
    logic        f, e, h, b;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic add(input logic rst, input logic rn, input logic stp, input logic bpe,
                     input logic [4:0] bpa, input logic [4:0] pca,
                     input logic f, input logic e, input logic h, input logic b,
                     input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.run = rn; v.stp = stp; v.bpe = bpe; v.bpa = bpa; v.pca = pca;
    v.f = f; v.e = e; v.h = h; v.b = b; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t x;
    logic [15:0] exp4;
    @(negedge clk);
    reset = v.rst; run = v.run; step = v.stp; bp_en = v.bpe;
    bp_addr = v.bpa; pc_addr = v.pca;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    exp4 = (x.cnt > 16'd15) ? 16'd15 : x.cnt;
    chk("fetch_en", idx, {31'd0, fetch_en}, {31'd0, x.f});
    chk("exec_en", idx, {31'd0, exec_en}, {31'd0, x.e});
    chk("halted", idx, {31'd0, halted}, {31'd0, x.h});
    chk("bp_hit", idx, {31'd0, bp_hit}, {31'd0, x.b});
    chk("instr_count", idx, {16'd0, instr_count}, {16'd0, x.cnt});
    chk("instr_count4", idx, {28'd0, instr_count4}, {16'd0, exp4});
  endtask

  initial begin
    // reset and idle
    add(1,0,0,0,0,0, 0,0,1,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 0,0,1,0,0);
    // free-run, then drop run while in FETCH
    for (int k = 1; k <= 9; k++)
      add(0,1,0,0,0,0, k[0], ~k[0], 0, 0, 16'((k-1)/2));
    add(0,0,0,0,0,0, 0,1,0,0,4);
    add(0,0,0,0,0,0, 0,0,1,0,5);
    add(0,0,0,0,0,0, 0,0,1,0,5);
    // held step gives one instruction, second edge gives another
    add(0,0,1,0,0,0, 1,0,0,0,5);
    add(0,0,1,0,0,0, 0,1,0,0,5);
    for (int i = 0; i < 8; i++) add(0,0,1,0,0,0, 0,0,1,0,6);
    add(0,0,0,0,0,0, 0,0,1,0,6);
    add(0,0,1,0,0,0, 1,0,0,0,6);
    add(0,0,1,0,0,0, 0,1,0,0,6);
    add(0,0,0,0,0,0, 0,0,1,0,7);
    add(0,0,0,0,0,0, 0,0,1,0,7);
    // breakpoint at 5, then step off it
    add(1,0,0,0,0,0, 0,0,1,0,0);
    add(0,1,0,1,5,0, 1,0,0,0,0);
    add(0,1,0,1,5,0, 0,1,0,0,0);
    add(0,1,0,1,5,1, 1,0,0,0,1);
    add(0,1,0,1,5,1, 0,1,0,0,1);
    add(0,1,0,1,5,2, 1,0,0,0,2);
    add(0,1,0,1,5,2, 0,1,0,0,2);
    add(0,1,0,1,5,3, 1,0,0,0,3);
    add(0,1,0,1,5,3, 0,1,0,0,3);
    add(0,1,0,1,5,4, 1,0,0,0,4);
    add(0,1,0,1,5,4, 0,1,0,0,4);
    add(0,1,0,1,5,5, 0,0,1,1,5);
    add(0,0,0,1,5,5, 0,0,1,1,5);
    add(0,0,0,1,5,5, 0,0,1,1,5);
    add(0,0,1,1,5,5, 1,0,0,0,5);
    add(0,0,0,1,5,6, 0,1,0,0,5);
    add(0,0,0,1,5,6, 0,0,1,0,6);
    add(0,0,0,1,5,6, 0,0,1,0,6);
    // run beats step; step outside HALT ignored; disabled breakpoint ignored
    add(0,1,1,0,5,0, 1,0,0,0,6);
    add(0,1,0,0,5,0, 0,1,0,0,6);
    add(0,1,1,0,5,5, 1,0,0,0,7);
    add(0,1,0,0,5,0, 0,1,0,0,7);
    add(0,0,0,0,5,0, 0,0,1,0,8);
    // reset mid-EXEC and mid-FETCH abandons the instruction
    add(0,1,0,0,0,0, 1,0,0,0,8);
    add(0,1,0,0,0,0, 0,1,0,0,8);
    add(1,1,0,0,0,0, 0,0,1,0,0);
    add(0,1,0,0,0,0, 1,0,0,0,0);
    add(0,1,0,0,0,0, 0,1,0,0,0);
    add(0,0,0,0,0,0, 0,0,1,0,1);
    add(0,1,0,0,0,0, 1,0,0,0,1);
    add(1,1,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,1,0,0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // saturation: 21 instructions, 4-bit counter must stick at 15
    begin
      vec_t v;
      int n;
      v.rst = 1; v.run = 0; v.stp = 0; v.bpe = 0; v.bpa = 0; v.pca = 0;
      v.f = 0; v.e = 0; v.h = 1; v.b = 0; v.cnt = 0;
      apply(v, 1000);
      v.rst = 0; v.run = 1;
      for (int k = 1; k <= 41; k++) begin
        v.f = k[0]; v.e = ~k[0]; v.h = 0; v.cnt = 16'((k-1)/2);
        apply(v, 1000 + k);
      end
      @(negedge clk);
      run = 1'b0;
      n = 0;
      while (!halted && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("halt_timeout", 2000, {31'd0, halted}, 32'd1);
      chk("sat_count", 2001, {16'd0, instr_count}, 32'd21);
      chk("sat_count4", 2002, {28'd0, instr_count4}, 32'd15);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_count4", 2003, {28'd0, instr_count4}, 32'd15);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run-control sequencer for the single-cycle-issue processor core. Replaces the free-running phase generator.
- Produces the fetch phase (program-memory enable) and the execute phase (register-file write enable).
- Adds halt, free-run, single-step and a single hardware PC breakpoint, driven from board switches/buttons or a debug host.
- Counts retired instructions for bring-up and profiling.

Parameters:
ADDR_WIDTH, 5, width of program-memory address (PC)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = free-run, 0 = halt after current instruction completes
step  input  1  single-step request; rising edge detected internally
bp_en  input  1  breakpoint enable
bp_addr  input  ADDR_WIDTH  breakpoint PC address
pc_addr  input  ADDR_WIDTH  next-instruction address from PC logic, valid during execute phase
fetch_en  output  1  program-memory load enable (fetch phase)
exec_en  output  1  register-file write enable (execute phase)
halted  output  1  core idle in HALT state
bp_hit  output  1  sticky; last halt caused by breakpoint
instr_count  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (reset=1 at clk edge): state=HALT, fetch_en=0, exec_en=0, halted=1, bp_hit=0, instr_count=0, step history register=0. Reset has priority over every other input in every state, including mid-FETCH and mid-EXEC; the partial instruction is abandoned and not counted.
- step_rise = step & ~step_q, where step_q is step registered every cycle in every state. A held step produces exactly one step.
- States: HALT, FETCH, EXEC. fetch_en=(state==FETCH), exec_en=(state==EXEC), halted=(state==HALT). All three are decoded from the state register only, so they are glitch-free with no combinational path from inputs.
- HALT:
  - run=1 -> FETCH; clear bp_hit; one_shot=0.
  - else step_rise=1 -> FETCH; clear bp_hit; one_shot=1.
  - else stay in HALT.
  - run and step_rise in the same cycle: run wins (one_shot=0).
- FETCH: unconditionally -> EXEC next cycle; inputs are ignored. An instruction, once fetched, always completes.
- EXEC: instr_count += 1, saturating at all-ones (no wrap). Next state, in priority order:
  1. one_shot=1 -> HALT.
  2. run=0 -> HALT.
  3. bp_en=1 and pc_addr==bp_addr -> HALT; set bp_hit=1.
  4. Otherwise -> FETCH.
- Breakpoint semantics:
  - The halt occurs before the instruction at bp_addr is fetched.
  - On resume, that instruction executes normally. The compare only examines the next PC during EXEC, so the core never re-halts on the address it resumes from unless the instruction branches to itself.
  - Step from a breakpoint executes exactly the bp_addr instruction.
- step_rise outside HALT is ignored (not queued).
- Timing:
  - Throughput: 1 instruction per 2 cycles in free-run.
  - Latency from run asserted in HALT to fetch_en=1: 1 cycle.
  - run deasserted during FETCH: instruction completes; HALT two edges later.
- bp_hit holds until the next HALT->FETCH transition or reset.
- instr_count holds its value while in HALT; it is cleared only by reset.

Test Plan:
- Reset, then run=0, step=0 for 5 cycles -> halted=1, fetch_en=exec_en=0, instr_count=0, bp_hit=0 throughout.
- run=1 for 8 cycles from HALT -> fetch_en/exec_en alternate starting 1 cycle after run; instr_count=4. Drop run during FETCH -> one more EXEC, then halted=1, instr_count=5.
- run=0, step held high for 10 cycles -> exactly one FETCH/EXEC pair, instr_count=1, halted=1. Release and raise step again -> instr_count=2.
- run=1, bp_en=1, bp_addr=5, pc_addr sequence 1,2,3,4,5 at successive EXECs -> halt after 5th instruction, bp_hit=1, no fetch_en after it. Pulse step -> bp_hit=0, one instruction, instr_count=6.
- CNT_WIDTH=4, free-run 20 instructions -> instr_count reaches 15 and stays 15.
- Assert reset during EXEC with run=1 -> next cycle halted=1, exec_en=0, instr_count=0. Keep run=1 and release reset -> fetch_en=1 one cycle later.
